// File: rtl/exb3_result_stage_pkg.sv
// Shared definitions for the EX3 result stage: memory status codes, deferred
// source kinds, fault codes, the null register ID and the load-op encoding.
package exb3_result_stage_pkg;

  localparam int         GPR_W_DEF  = 7;
  localparam logic [6:0] ZZR_ID_DEF = 7'h3F;

  // UMEM_OK status codes returned by the L1 alongside load data
  localparam logic [1:0] UMEM_OK_READY = 2'b00;
  localparam logic [1:0] UMEM_OK_OK    = 2'b01;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
  localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

  // Where a deferred EX2 result gets its final value
  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_MEM  = 2'd1;
  localparam logic [1:0] KIND_FPU  = 2'd2;
  localparam logic [1:0] KIND_KRR  = 2'd3;

  // exFaultCode values
  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_MEM  = 2'd1;
  localparam logic [1:0] FAULT_TMO  = 2'd2;

  // Load op: [1:0] access size, [2] zero-extend instead of sign-extend
  localparam logic [1:0] LD_SZ_B    = 2'd0;
  localparam logic [1:0] LD_SZ_W    = 2'd1;
  localparam logic [1:0] LD_SZ_L    = 2'd2;
  localparam logic [1:0] LD_SZ_Q    = 2'd3;
  localparam int         LD_UNS_BIT = 2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_FLT  = 2'd2
  } exb3State_t;

endpackage

// File: rtl/exb3_result_stage_if.sv
// Lane-side bundle of the EX3 result stage: EX2 result in, deferred sources
// in, writeback and hold/fault status out.
interface exb3_result_stage_if #(
  parameter int GPR_W = 7
);
  logic             pipeHold;
  logic             opBraFlush;
  logic [GPR_W-1:0] ex2IdRn;
  logic [63:0]      ex2ValRn;
  logic             ex2Held;
  logic [1:0]       ex2Kind;
  logic [2:0]       ex2LdOp;
  logic [63:0]      memDataIn;
  logic [1:0]       memOk;
  logic [63:0]      fpuVecRes;
  logic             fpuVecOk;
  logic [63:0]      krrRes;
  logic [GPR_W-1:0] regIdRn3;
  logic [63:0]      regValRn3;
  logic             exHold;
  logic             regHeld3;
  logic             exFault;
  logic [1:0]       exFaultCode;

  modport master (
    output pipeHold, opBraFlush, ex2IdRn, ex2ValRn, ex2Held, ex2Kind, ex2LdOp,
           memDataIn, memOk, fpuVecRes, fpuVecOk, krrRes,
    input  regIdRn3, regValRn3, exHold, regHeld3, exFault, exFaultCode
  );

  modport slave (
    input  pipeHold, opBraFlush, ex2IdRn, ex2ValRn, ex2Held, ex2Kind, ex2LdOp,
           memDataIn, memOk, fpuVecRes, fpuVecOk, krrRes,
    output regIdRn3, regValRn3, exHold, regHeld3, exFault, exFaultCode
  );
endinterface

// File: rtl/exb3_result_stage_load_extract.sv
// Size/sign extraction of right-aligned L1 load data according to the load op.
module exb3_load_extract
  import exb3_result_stage_pkg::*;
(
  input  logic [63:0] memData,
  input  logic [2:0]  ldOp,
  output logic [63:0] ldVal
);

  function automatic logic [63:0] extendField(input logic [63:0] raw,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [63:0] res;
    res = raw;
    case (size)
      LD_SZ_B: res = {{56{!uns && raw[7]}},  raw[7:0]};
      LD_SZ_W: res = {{48{!uns && raw[15]}}, raw[15:0]};
      LD_SZ_L: res = {{32{!uns && raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Pure combinational extraction; quadword loads pass straight through
  always_comb ldVal = extendField(memData, ldOp[1:0], ldOp[LD_UNS_BIT]);

endmodule

// File: rtl/exb3_result_stage.sv
// EX3 result stage for execute lanes 2+: registers the EX2 result, completes
// deferred results (load, FPU vector, keyring), stalls the pipe while a
// deferred source is not ready and turns an overlong wait into a fault.
module exb3_result_stage
  import exb3_result_stage_pkg::*;
#(
  parameter int               GPR_W    = GPR_W_DEF,
  parameter logic [GPR_W-1:0] ZZR_ID   = GPR_W'(ZZR_ID_DEF),
  parameter int               WAIT_MAX = 255
) (
  input  logic clock,
  input  logic reset,
  exb3_result_stage_if.slave bus
);

  localparam int               CNT_W      = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

  logic [GPR_W-1:0] idRn_p1;
  logic [63:0]      valRn_p1;
  logic             held_p1;
  logic [1:0]       kind_p1;
  logic [2:0]       ldOp_p1;

  exb3State_t       state, stateNext;
  logic [CNT_W-1:0] waitCnt, waitCntNext, cntStep;
  logic             faultLatch;

  logic [63:0]      ldVal, srcVal;
  logic             srcWait, srcFault;
  logic             holdReq, faultPulse, advance;
  logic [1:0]       faultCode;
  logic [GPR_W-1:0] idOut;

  exb3_load_extract uLoadExtract (
    .memData (bus.memDataIn),
    .ldOp    (ldOp_p1),
    .ldVal   (ldVal)
  );

  assign advance = !bus.pipeHold && !holdReq;

  // ---- EX2 -> EX3 boundary: stage register, frozen by stalls and own hold
  always_ff @(posedge clock) begin
    if (reset) begin
      idRn_p1  <= ZZR_ID;
      valRn_p1 <= '0;
      held_p1  <= 1'b0;
      kind_p1  <= KIND_NONE;
      ldOp_p1  <= '0;
    end else if (advance) begin
      idRn_p1  <= bus.opBraFlush ? ZZR_ID : bus.ex2IdRn;
      valRn_p1 <= bus.ex2ValRn;
      held_p1  <= bus.ex2Held && !bus.opBraFlush;
      kind_p1  <= bus.ex2Kind;
      ldOp_p1  <= bus.ex2LdOp;
    end
  end

  // Resolve the deferred source: final value, not-ready, or memory fault
  always_comb begin
    srcVal   = valRn_p1;
    srcWait  = 1'b0;
    srcFault = 1'b0;
    if (held_p1) begin
      case (kind_p1)
        KIND_MEM: begin
          if (bus.memOk == UMEM_OK_OK)         srcVal   = ldVal;
          else if (bus.memOk == UMEM_OK_FAULT) srcFault = 1'b1;
          else                                 srcWait  = 1'b1;
        end
        KIND_FPU: begin
          if (bus.fpuVecOk) srcVal  = bus.fpuVecRes;
          else              srcWait = 1'b1;
        end
        KIND_KRR: srcVal = bus.krrRes;
        default:  srcVal = valRn_p1;
      endcase
    end
  end

  // Wait FSM next state plus hold/fault outputs; a latched fault kills the
  // instruction still sitting in the register so it cannot fault twice
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    holdReq     = 1'b0;
    faultPulse  = 1'b0;
    faultCode   = FAULT_NONE;
    idOut       = idRn_p1;
    cntStep     = (state == ST_WAIT) ? waitCnt + CNT_W'(1) : CNT_W'(1);
    if (faultLatch) begin
      idOut       = ZZR_ID;
      stateNext   = ST_RUN;
      waitCntNext = '0;
    end else if (state == ST_FLT) begin
      idOut       = ZZR_ID;
      faultPulse  = 1'b1;
      faultCode   = srcFault ? FAULT_MEM : FAULT_TMO;
      stateNext   = ST_RUN;
      waitCntNext = '0;
    end else if (srcFault) begin
      idOut       = ZZR_ID;
      faultPulse  = 1'b1;
      faultCode   = FAULT_MEM;
      stateNext   = ST_RUN;
      waitCntNext = '0;
    end else if (srcWait) begin
      holdReq     = 1'b1;
      waitCntNext = cntStep;
      stateNext   = (cntStep >= WAIT_LIMIT) ? ST_FLT : ST_WAIT;
    end else begin
      stateNext   = ST_RUN;
      waitCntNext = '0;
    end
  end

  // FSM state, wait counter and the one-shot fault latch
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_RUN;
      waitCnt    <= '0;
      faultLatch <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      faultLatch <= advance ? 1'b0 : (faultLatch | faultPulse);
    end
  end

  // ---- EX3 outputs
  assign bus.regIdRn3    = idOut;
  assign bus.regValRn3   = srcVal;
  assign bus.exHold      = holdReq;
  assign bus.regHeld3    = holdReq;
  assign bus.exFault     = faultPulse;
  assign bus.exFaultCode = faultCode;

endmodule

// File: tb/tb_exb3_result_stage.sv
// Testbench for exb3_result_stage: directed scenarios plus a randomized run
// against a rule-level reference model of the stage.
module tb_exb3_result_stage;
  import exb3_result_stage_pkg::*;

  localparam logic [6:0] ZZR  = 7'h3F;
  localparam int         WMAX = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   failed   = 0;

  exb3_result_stage_if #(.GPR_W(7)) bus ();

  exb3_result_stage #(.GPR_W(7), .ZZR_ID(7'h3F), .WAIT_MAX(WMAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference load extraction: keep the low 8*2^size bits, then fill upward
  function automatic logic [63:0] refLoad(input logic [63:0] d, input logic [2:0] op);
    int          nbits;
    logic [63:0] mask, v;
    nbits = 8 << op[1:0];
    if (nbits == 64) return d;
    mask = (64'd1 << nbits) - 64'd1;
    v    = d & mask;
    if (!op[2] && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.pipeHold = 0; bus.opBraFlush = 0; bus.ex2IdRn = ZZR; bus.ex2ValRn = 0;
    bus.ex2Held = 0; bus.ex2Kind = KIND_NONE; bus.ex2LdOp = 0; bus.memDataIn = 0;
    bus.memOk = UMEM_OK_READY; bus.fpuVecRes = 0; bus.fpuVecOk = 0; bus.krrRes = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    compared++; if (bus.regIdRn3 !== ZZR) begin failed++; $display("FAIL reset_id got %h want %h", bus.regIdRn3, ZZR); end
    compared++; if (bus.regValRn3 !== 64'd0) begin failed++; $display("FAIL reset_val got %h want 0", bus.regValRn3); end
    compared++; if (bus.exHold !== 1'b0) begin failed++; $display("FAIL reset_exHold got %b want 0", bus.exHold); end
    compared++; if (bus.regHeld3 !== 1'b0) begin failed++; $display("FAIL reset_regHeld3 got %b want 0", bus.regHeld3); end
    compared++; if (bus.exFault !== 1'b0) begin failed++; $display("FAIL reset_exFault got %b want 0", bus.exFault); end
  endtask

  task automatic test_forward();
    bus.ex2IdRn = 7'd5; bus.ex2ValRn = 64'h1234; bus.ex2Held = 0;
    tick();
    drive_idle();
    #1;
    compared++; if (bus.regIdRn3 !== 7'd5) begin failed++; $display("FAIL fwd_id got %h want 05", bus.regIdRn3); end
    compared++; if (bus.regValRn3 !== 64'h1234) begin failed++; $display("FAIL fwd_val got %h want 1234", bus.regValRn3); end
    compared++; if (bus.exHold !== 1'b0) begin failed++; $display("FAIL fwd_exHold got %b want 0", bus.exHold); end
  endtask

  task automatic test_load(input logic [2:0] op, input logic [63:0] expV);
    int holds;
    bus.ex2IdRn = 7'd6; bus.ex2Held = 1; bus.ex2Kind = KIND_MEM; bus.ex2LdOp = op;
    bus.ex2ValRn = 64'hDEAD; bus.memOk = UMEM_OK_HOLD;
    tick();
    bus.ex2IdRn = 7'd10; bus.ex2Held = 0; bus.ex2Kind = KIND_NONE; bus.ex2ValRn = 64'h10;
    holds = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.exHold === 1'b1 && bus.regHeld3 === 1'b1 && bus.regIdRn3 === 7'd6) holds++;
      tick();
      bus.ex2IdRn = 7'd11; bus.ex2ValRn = 64'h11;
    end
    compared++; if (holds !== 3) begin failed++; $display("FAIL load_hold_cycles op=%b got %0d want 3", op, holds); end
    bus.memOk = UMEM_OK_OK; bus.memDataIn = 64'h80;
    #1;
    compared++; if (bus.exHold !== 1'b0 || bus.regHeld3 !== 1'b0) begin failed++; $display("FAIL load_release op=%b got hold=%b held3=%b want 0 0", op, bus.exHold, bus.regHeld3); end
    compared++; if (bus.regValRn3 !== expV) begin failed++; $display("FAIL load_val op=%b got %h want %h", op, bus.regValRn3, expV); end
    compared++; if (bus.regIdRn3 !== 7'd6) begin failed++; $display("FAIL load_id op=%b got %h want 06", op, bus.regIdRn3); end
    tick();
    drive_idle();
    #1;
    compared++; if (bus.regIdRn3 !== 7'd11) begin failed++; $display("FAIL load_next_id op=%b got %h want 0b", op, bus.regIdRn3); end
  endtask

  task automatic test_timeout();
    int holds;
    bus.ex2IdRn = 7'd12; bus.ex2Held = 1; bus.ex2Kind = KIND_FPU; bus.fpuVecOk = 0;
    tick();
    bus.ex2IdRn = 7'd13; bus.ex2Held = 0; bus.ex2Kind = KIND_NONE; bus.ex2ValRn = 64'h1313;
    holds = 0;
    while (holds < 20) begin
      #1;
      if (bus.exHold !== 1'b1) break;
      holds++;
      tick();
    end
    compared++; if (holds !== WMAX) begin failed++; $display("FAIL tmo_hold_cycles got %0d want %0d", holds, WMAX); end
    compared++; if (bus.exFault !== 1'b1) begin failed++; $display("FAIL tmo_fault got %b want 1", bus.exFault); end
    compared++; if (bus.exFaultCode !== FAULT_TMO) begin failed++; $display("FAIL tmo_code got %0d want 2", bus.exFaultCode); end
    compared++; if (bus.regIdRn3 !== ZZR) begin failed++; $display("FAIL tmo_id got %h want %h", bus.regIdRn3, ZZR); end
    tick();
    drive_idle();
    #1;
    compared++; if (bus.exFault !== 1'b0) begin failed++; $display("FAIL tmo_fault_once got %b want 0", bus.exFault); end
    compared++; if (bus.regIdRn3 !== 7'd13 || bus.regValRn3 !== 64'h1313) begin failed++; $display("FAIL tmo_resume got id=%h val=%h want 0d 1313", bus.regIdRn3, bus.regValRn3); end
  endtask

  task automatic test_mem_fault();
    bus.ex2IdRn = 7'd14; bus.ex2Held = 1; bus.ex2Kind = KIND_MEM; bus.ex2LdOp = 3'b011;
    bus.memOk = UMEM_OK_FAULT;
    tick();
    bus.ex2IdRn = 7'd16; bus.ex2Held = 0; bus.ex2Kind = KIND_NONE; bus.ex2ValRn = 64'h16;
    #1;
    compared++; if (bus.exFault !== 1'b1 || bus.exFaultCode !== FAULT_MEM) begin failed++; $display("FAIL mflt_pulse got fault=%b code=%0d want 1 1", bus.exFault, bus.exFaultCode); end
    compared++; if (bus.regIdRn3 !== ZZR || bus.exHold !== 1'b0) begin failed++; $display("FAIL mflt_id got id=%h hold=%b want %h 0", bus.regIdRn3, bus.exHold, ZZR); end
    tick();
    #1;
    compared++; if (bus.exFault !== 1'b0 || bus.regIdRn3 !== 7'd16) begin failed++; $display("FAIL mflt_after got fault=%b id=%h want 0 10", bus.exFault, bus.regIdRn3); end
    drive_idle();
  endtask

  task automatic test_fault_pipehold();
    int pulses;
    bus.ex2IdRn = 7'd15; bus.ex2Held = 1; bus.ex2Kind = KIND_MEM; bus.memOk = UMEM_OK_FAULT;
    tick();
    bus.ex2IdRn = 7'd17; bus.ex2Held = 0; bus.ex2Kind = KIND_NONE; bus.ex2ValRn = 64'h17;
    bus.pipeHold = 1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.exFault === 1'b1) pulses++;
      compared++; if (bus.regIdRn3 !== ZZR) begin failed++; $display("FAIL fph_id cyc=%0d got %h want %h", i, bus.regIdRn3, ZZR); end
      tick();
    end
    compared++; if (pulses !== 1) begin failed++; $display("FAIL fph_pulses got %0d want 1", pulses); end
    bus.pipeHold = 0;
    tick();
    #1;
    compared++; if (bus.regIdRn3 !== 7'd17 || bus.exFault !== 1'b0) begin failed++; $display("FAIL fph_resume got id=%h fault=%b want 11 0", bus.regIdRn3, bus.exFault); end
    drive_idle();
  endtask

  task automatic test_flush_stall();
    bus.ex2IdRn = 7'd9; bus.ex2ValRn = 64'h9; bus.opBraFlush = 1;
    tick();
    bus.opBraFlush = 0; bus.ex2IdRn = 7'd20; bus.ex2ValRn = 64'hA0A0;
    #1;
    compared++; if (bus.regIdRn3 !== ZZR) begin failed++; $display("FAIL flush_id got %h want %h", bus.regIdRn3, ZZR); end
    tick();
    bus.pipeHold = 1; bus.ex2IdRn = 7'd21; bus.ex2ValRn = 64'hB1B1;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++; if (bus.regIdRn3 !== 7'd20 || bus.regValRn3 !== 64'hA0A0) begin failed++; $display("FAIL stall_hold cyc=%0d got id=%h val=%h want 14 a0a0", i, bus.regIdRn3, bus.regValRn3); end
      if (i < 2) tick();
    end
    bus.pipeHold = 0;
    tick();
    #1;
    compared++; if (bus.regIdRn3 !== 7'd21 || bus.regValRn3 !== 64'hB1B1) begin failed++; $display("FAIL stall_release got id=%h val=%h want 15 b1b1", bus.regIdRn3, bus.regValRn3); end
    drive_idle();
  endtask

  task automatic test_reset_wait();
    int holds;
    bus.ex2IdRn = 7'd22; bus.ex2Held = 1; bus.ex2Kind = KIND_FPU; bus.fpuVecOk = 0;
    tick();
    drive_idle();
    tick();
    tick();
    #1;
    compared++; if (bus.exHold !== 1'b1) begin failed++; $display("FAIL rstw_waiting got %b want 1", bus.exHold); end
    reset = 1;
    tick();
    reset = 0;
    #1;
    compared++; if (bus.regIdRn3 !== ZZR || bus.exHold !== 1'b0) begin failed++; $display("FAIL rstw_cleared got id=%h hold=%b want %h 0", bus.regIdRn3, bus.exHold, ZZR); end
    bus.ex2IdRn = 7'd23; bus.ex2Held = 1; bus.ex2Kind = KIND_FPU; bus.fpuVecOk = 0;
    tick();
    drive_idle();
    holds = 0;
    while (holds < 20) begin
      #1;
      if (bus.exHold !== 1'b1) break;
      holds++;
      tick();
    end
    compared++; if (holds !== WMAX || bus.exFault !== 1'b1) begin failed++; $display("FAIL rstw_fresh_count got holds=%0d fault=%b want %0d 1", holds, bus.exFault, WMAX); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  mId, eId;
    logic [63:0] mVal, eVal;
    logic        mHeld;
    logic [1:0]  mKind, eCode;
    logic [2:0]  mOp;
    int          holdRun, r;
    bit          killed, eHold, eFault, valChk;
    do_reset();
    mId = ZZR; mVal = 0; mHeld = 0; mKind = KIND_NONE; mOp = 0; holdRun = 0; killed = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.ex2IdRn    = 7'($urandom_range(0, 63));
      bus.ex2ValRn   = {$urandom, $urandom};
      bus.ex2Held    = 1'($urandom_range(0, 1));
      bus.ex2Kind    = 2'($urandom_range(0, 3));
      bus.ex2LdOp    = 3'($urandom_range(0, 7));
      bus.opBraFlush = ($urandom_range(0, 7) == 0);
      bus.pipeHold   = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 7);
      bus.memOk      = (r == 0) ? UMEM_OK_READY : (r == 1) ? UMEM_OK_HOLD : UMEM_OK_OK;
      bus.memDataIn  = {$urandom, $urandom};
      bus.fpuVecOk   = ($urandom_range(0, 3) != 0);
      bus.fpuVecRes  = {$urandom, $urandom};
      bus.krrRes     = {$urandom, $urandom};
      #1;
      eId = mId; eVal = mVal; eHold = 0; eFault = 0; eCode = FAULT_NONE; valChk = 1;
      if (killed) begin
        eId = ZZR; valChk = 0;
      end else if (holdRun == WMAX) begin
        eId = ZZR; eFault = 1; eCode = FAULT_TMO; valChk = 0;
      end else if (mHeld && mKind == KIND_MEM && bus.memOk != UMEM_OK_OK) begin
        eHold = 1; valChk = 0;
      end else if (mHeld && mKind == KIND_FPU && !bus.fpuVecOk) begin
        eHold = 1; valChk = 0;
      end else if (mHeld) begin
        if (mKind == KIND_MEM)      eVal = refLoad(bus.memDataIn, mOp);
        else if (mKind == KIND_FPU) eVal = bus.fpuVecRes;
        else if (mKind == KIND_KRR) eVal = bus.krrRes;
      end
      compared++; if (bus.regIdRn3 !== eId) begin failed++; $display("FAIL rnd_id cyc=%0d got %h want %h", cyc, bus.regIdRn3, eId); end
      compared++; if (bus.exHold !== eHold || bus.regHeld3 !== eHold) begin failed++; $display("FAIL rnd_hold cyc=%0d got hold=%b held3=%b want %b", cyc, bus.exHold, bus.regHeld3, eHold); end
      compared++; if (bus.exFault !== eFault) begin failed++; $display("FAIL rnd_fault cyc=%0d got %b want %b", cyc, bus.exFault, eFault); end
      if (eFault) begin
        compared++; if (bus.exFaultCode !== eCode) begin failed++; $display("FAIL rnd_code cyc=%0d got %0d want %0d", cyc, bus.exFaultCode, eCode); end
      end
      if (valChk) begin
        compared++; if (bus.regValRn3 !== eVal) begin failed++; $display("FAIL rnd_val cyc=%0d got %h want %h", cyc, bus.regValRn3, eVal); end
      end
      holdRun = eHold ? holdRun + 1 : 0;
      if (!bus.pipeHold && !eHold) begin
        killed = 0;
        mId    = bus.opBraFlush ? ZZR : bus.ex2IdRn;
        mVal   = bus.ex2ValRn;
        mHeld  = bus.ex2Held && !bus.opBraFlush;
        mKind  = bus.ex2Kind;
        mOp    = bus.ex2LdOp;
      end else if (eFault) begin
        killed = 1;
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_forward();
    test_load(3'b000, 64'hFFFF_FFFF_FFFF_FF80);
    test_load(3'b100, 64'h0000_0000_0000_0080);
    test_timeout();
    test_mem_fault();
    test_fault_pipehold();
    test_flush_stall();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/exb3_result_stage.md
Name: exb3_result_stage

Overview:
- EX3 stage for execute lanes 2+.
- Registers the lane's EX2 result (destination ID, value, held flag) and completes deferred results: memory loads, FPU vector ops and keyring reads.
- Drives the writeback ID/value for the lane.
- Raises a pipeline hold while a deferred source is not ready; converts an overlong wait into a fault.

Parameters:
- GPR_W, 7, width of register IDs (matches codebase gpr width).
- ZZR_ID, 7'h3F, null-destination register ID (JX2_GR_ZZR).
- WAIT_MAX, 255, maximum hold cycles before a deferred-result timeout fault.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- pipeHold  in  1  global stall; stage register does not advance
- opBraFlush  in  1  flush of the instruction entering EX3
- ex2IdRn  in  GPR_W  EX2 destination ID
- ex2ValRn  in  64  EX2 destination value
- ex2Held  in  1  EX2 result is deferred (EX2 regHeld)
- ex2Kind  in  2  deferred source: 0 none, 1 mem load, 2 FPU vector, 3 keyring
- ex2LdOp  in  3  load format: [1:0] size B/W/L/Q, [2] unsigned
- memDataIn  in  64  L1 load data (right-aligned)
- memOk  in  2  UMEM_OK code: 00 READY, 01 OK, 10 HOLD, 11 FAULT
- fpuVecRes  in  64  FPU vector result
- fpuVecOk  in  1  FPU vector result valid
- krrRes  in  64  keyring result
- regIdRn3  out  GPR_W  writeback destination ID
- regValRn3  out  64  writeback value
- exHold  out  1  stall request to pipeline
- regHeld3  out  1  value on regValRn3 not yet valid (forwarding must stall)
- exFault  out  1  one-cycle fault pulse
- exFaultCode  out  2  1 mem fault, 2 timeout

Behaviour:
- Reset (sync): stage register ID=ZZR_ID, val=0, held=0, kind=0; state=RUN; waitCnt=0; exFault=0. Consequently regIdRn3=ZZR_ID, regValRn3=0, exHold=0, regHeld3=0.
- Stage register: loads on every clock with !pipeHold && !exHold. If opBraFlush is asserted on the load edge, it loads ID=ZZR_ID and held=0.
- Outputs are combinational from the stage register and the deferred sources. Latency EX2→EX3 is 1 cycle.
- held=0: regIdRn3/regValRn3 = registered ID/value; exHold=0.
- held=1, kind=1 (mem load):
  - memOk=OK: value = memDataIn extracted per LdOp. B/W/L sign-extend, or zero-extend when [2]=1; Q passes through.
  - memOk=READY/HOLD: exHold=1, regHeld3=1.
  - memOk=FAULT: ID forced to ZZR_ID; exFault=1, code=1.
- held=1, kind=2: fpuVecOk ? value=fpuVecRes : (exHold=1, regHeld3=1).
- held=1, kind=3: value=krrRes, no wait.
- held=1, kind=0: treated as kind 3 with value = registered value; no hold.
- FSM:
  - RUN→WAIT when exHold is first asserted; waitCnt=1.
  - WAIT: waitCnt increments each cycle while exHold. WAIT→RUN when the source becomes ready.
  - When waitCnt==WAIT_MAX and still not ready: go to FLT for one cycle. In FLT: exFault=1, code=2, ID=ZZR_ID, exHold=0, stage register advances; then return to RUN.
- Simultaneous events:
  - exHold has priority over a new EX2 result; the EX2 input is ignored while held.
  - pipeHold with a ready source: output stays valid and the register does not advance.
  - Mem FAULT and timeout on the same cycle: code=1.
- exFault is asserted for exactly one cycle per faulting instruction, even if pipeHold persists. A latch suppresses repeat pulses until the register advances.
- Reset mid-wait: returns to RUN, waitCnt=0, the pending instruction is discarded (ID=ZZR_ID).

Decomposition:
- Shared package (CoreDefs): UMEM_OK_* codes, deferred-kind codes, fault codes, ZZR ID, load-op encoding.
- One natural sub-module: exb3_load_extract. Combinational size/sign extraction of memDataIn by LdOp; reusable by lane 1.

Test Plan:
- Non-held forward: ID=5, val=64'h1234 → next cycle regIdRn3=5, regValRn3=64'h1234, exHold=0.
- Load byte signed: kind=1, LdOp=000, memOk=HOLD for 3 cycles then OK with data 64'h80 → exHold high for 3 cycles; then regValRn3=64'hFFFF_FFFF_FFFF_FF80, regHeld3=0. Repeat with LdOp=100 → 64'h80.
- Timeout: kind=2, fpuVecOk stays 0 with WAIT_MAX=8 → exHold for 8 cycles; then one exFault pulse, code=2, regIdRn3=ZZR_ID; pipeline resumes.
- Mem fault: kind=1, memOk=FAULT → exFault=1 for one cycle, code=1, regIdRn3=ZZR_ID.
- Flush and stall: opBraFlush with ID=9 → regIdRn3=ZZR_ID. pipeHold=1 for 2 cycles → output held constant and the EX2 change is not captured.
- Reset during WAIT → next cycle regIdRn3=ZZR_ID, exHold=0, state RUN.
